// File: rtl/vga_timing_pkg.sv
// Shared types and default 640x480@60 constants for the raster timing generator.
// Optional feature macro: VGA_TIMING_IRQ_EN (vertical-blank interrupt flag).
package vga_timing_pkg;

  typedef enum logic [1:0] {R_ACTIVE, R_FRONT, R_SYNC, R_BACK} region_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;
  localparam int DEF_CW       = 10;

  function automatic int seg_total(input int active, input int front, input int sync,
                                   input int back);
    return active + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Raster timing bundle between vga_timing (master) and its consumers (slave).
// Optional feature macro: VGA_TIMING_IRQ_EN adds vblank_irq / irq_ack.
interface vga_timing_if #(
  parameter int CW = 10
);
  logic          hsync;
  logic          vsync;
  logic          h_active;
  logic          v_active;
  logic          eol;
  logic          eof;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
`ifdef VGA_TIMING_IRQ_EN
  logic          vblank_irq;
  logic          irq_ack;

  modport master (
    output hsync, vsync, h_active, v_active, eol, eof, x, y, vblank_irq,
    input  irq_ack
  );
  modport slave (
    input  hsync, vsync, h_active, v_active, eol, eof, x, y, vblank_irq,
    output irq_ack
  );
`else
  modport master (
    output hsync, vsync, h_active, v_active, eol, eof, x, y
  );
  modport slave (
    input  hsync, vsync, h_active, v_active, eol, eof, x, y
  );
`endif
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter plus ACTIVE/FRONT/SYNC/BACK region tracking.
// Used once for pixels (inc every clock) and once for lines (inc on line wrap).
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int CW = 10
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          inc,
  input  logic [CW-1:0] len_active,
  input  logic [CW-1:0] len_front,
  input  logic [CW-1:0] len_sync,
  input  logic [CW-1:0] len_back,
  output logic [CW-1:0] count,
  output region_t       region,
  output logic          wrap
);

  logic [CW-1:0] count_q, count_d;
  region_t       region_q, region_d;

  // Last count of each segment, one bit wider so a total of 2^CW does not overflow.
  logic [CW:0] end_active, end_front, end_sync, end_total, count_x;

  always_comb begin
    end_active = {1'b0, len_active} - 1'b1;
    end_front  = end_active + {1'b0, len_front};
    end_sync   = end_front  + {1'b0, len_sync};
    end_total  = end_sync   + {1'b0, len_back};
    count_x    = {1'b0, count_q};
    wrap       = inc && (count_x == end_total);

    count_d  = count_q;
    region_d = region_q;
    if (inc) begin
      count_d = wrap ? '0 : count_q + 1'b1;
      if (wrap)                         region_d = R_ACTIVE;
      else if (count_x == end_active)   region_d = R_FRONT;
      else if (count_x == end_front)    region_d = R_SYNC;
      else if (count_x == end_sync)     region_d = R_BACK;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      count_q  <= '0;
      region_q <= R_ACTIVE;
    end else begin
      count_q  <= count_d;
      region_q <= region_d;
    end
  end

  assign count  = count_q;
  assign region = region_q;

endmodule

// File: rtl/vga_timing.sv
// Free-running VGA raster timing generator; all outputs registered, one cycle behind the counters.
// Optional feature macro: VGA_TIMING_IRQ_EN builds the sticky vblank_irq flag.
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FRONT  = DEF_V_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = DEF_CW
) (
  input  logic clk_i,
  input  logic rst_i,
  vga_timing_if.master vif
);

  localparam int H_TOTAL = seg_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = seg_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

  logic [CW-1:0] h_count, v_count;
  region_t       h_region, v_region;
  logic          h_wrap, v_wrap;

  vga_axis_counter #(.CW(CW)) u_h_axis (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .inc        (1'b1),
    .len_active (CW'(H_ACTIVE)),
    .len_front  (CW'(H_FRONT)),
    .len_sync   (CW'(H_SYNC)),
    .len_back   (CW'(H_BACK)),
    .count      (h_count),
    .region     (h_region),
    .wrap       (h_wrap)
  );

  vga_axis_counter #(.CW(CW)) u_v_axis (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .inc        (h_wrap),
    .len_active (CW'(V_ACTIVE)),
    .len_front  (CW'(V_FRONT)),
    .len_sync   (CW'(V_SYNC)),
    .len_back   (CW'(V_BACK)),
    .count      (v_count),
    .region     (v_region),
    .wrap       (v_wrap)
  );

  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          h_active_q, h_active_d;
  logic          v_active_q, v_active_d;
  logic          eol_q, eol_d;
  logic          eof_q, eof_d;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;

  always_comb begin
    hsync_d    = (h_region == R_SYNC) ? HS_POL : ~HS_POL;
    vsync_d    = (v_region == R_SYNC) ? VS_POL : ~VS_POL;
    h_active_d = (h_region == R_ACTIVE);
    v_active_d = (v_region == R_ACTIVE);
    eol_d      = (h_count == CW'(H_ACTIVE - 1));
    eof_d      = v_wrap;
    x_d        = h_count;
    y_d        = v_count;
  end

  // Output register stage: decode of the current counters becomes visible next cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      hsync_q    <= ~HS_POL;
      vsync_q    <= ~VS_POL;
      h_active_q <= 1'b0;
      v_active_q <= 1'b0;
      eol_q      <= 1'b0;
      eof_q      <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
    end else begin
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      h_active_q <= h_active_d;
      v_active_q <= v_active_d;
      eol_q      <= eol_d;
      eof_q      <= eof_d;
      x_q        <= x_d;
      y_q        <= y_d;
    end
  end

  assign vif.hsync    = hsync_q;
  assign vif.vsync    = vsync_q;
  assign vif.h_active = h_active_q;
  assign vif.v_active = v_active_q;
  assign vif.eol      = eol_q;
  assign vif.eof      = eof_q;
  assign vif.x        = x_q;
  assign vif.y        = y_q;

`ifdef VGA_TIMING_IRQ_EN
  logic irq_set;
  logic vblank_irq_q, vblank_irq_d;

  // Set on the first pixel of the first line after the visible area; set beats ack.
  always_comb begin
    irq_set      = (h_count == '0) && (v_count == CW'(V_ACTIVE));
    vblank_irq_d = irq_set | (vblank_irq_q & ~vif.irq_ack);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) vblank_irq_q <= 1'b0;
    else        vblank_irq_q <= vblank_irq_d;
  end

  assign vif.vblank_irq = vblank_irq_q;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Scoreboard bench: two vga_timing instances (reduced active-high and default 640x480 timing)
// checked cycle by cycle against an arithmetic raster model, plus line/frame-level measurements.
module tb_vga_timing;
  import vga_timing_pkg::*;

  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic       h_active;
    logic       v_active;
    logic       eol;
    logic       eof;
    logic       irq;
    logic [9:0] x;
    logic [9:0] y;
  } ev_t;

  typedef struct packed {
    ev_t  ev;
    logic in_rst;
  } exp_t;

  typedef struct packed {
    int   ha, hf, hs, hb, va, vf, vs, vb;
    logic hp, vp;
  } prm_t;

  localparam int S_HA = 8, S_HF = 2, S_HS = 2, S_HB = 2;
  localparam int S_VA = 4, S_VF = 1, S_VS = 1, S_VB = 1;
  localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
  localparam prm_t PS = '{ha:S_HA, hf:S_HF, hs:S_HS, hb:S_HB,
                          va:S_VA, vf:S_VF, vs:S_VS, vb:S_VB, hp:1'b1, vp:1'b1};
  localparam prm_t PD = '{ha:640, hf:16, hs:96, hb:48,
                          va:480, vf:10, vs:2, vb:33, hp:1'b0, vp:1'b0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ack_s = 1'b0;
  logic ack_d = 1'b0;

  always #5 clk = ~clk;

  vga_timing_if #(.CW(10)) vif_s ();
  vga_timing_if #(.CW(10)) vif_d ();

`ifdef VGA_TIMING_IRQ_EN
  assign vif_s.irq_ack = ack_s;
  assign vif_d.irq_ack = ack_d;
`endif

  vga_timing #(
    .H_ACTIVE(S_HA), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_ACTIVE(S_VA), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(10)
  ) dut_s (
    .clk_i (clk),
    .rst_i (rst_n),
    .vif   (vif_s.master)
  );

  vga_timing #(.CW(10)) dut_d (
    .clk_i (clk),
    .rst_i (rst_n),
    .vif   (vif_d.master)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_print = 0;

  exp_t q_s[$];
  exp_t q_d[$];

  // Reference model state
  int   hc[2];
  int   vc[2];
  logic irq_m[2];

  // Measurement state per instance
  int   since_rise[2], ha_run[2], hs_run[2], eol_gap[2], fgap[2], eol_cnt[2], eol_va[2];
  bit   rise_ok[2], eol_seen[2], prev_ha[2], prev_hs[2];

  task automatic cmp_int(input string nm, input int got, input int want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      if (n_print < 40) begin
        n_print++;
        $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, want, $time);
      end
    end
  endtask

  task automatic model_step(input int i, input prm_t p, input logic rn, input logic ack,
                            output exp_t e);
    int ht, vt, hsb, vsb;
    ht  = p.ha + p.hf + p.hs + p.hb;
    vt  = p.va + p.vf + p.vs + p.vb;
    hsb = p.ha + p.hf;
    vsb = p.va + p.vf;
    e = '0;
    e.in_rst = !rn;
    if (!rn) begin
      e.ev.hsync = ~p.hp;
      e.ev.vsync = ~p.vp;
      hc[i] = 0;
      vc[i] = 0;
      irq_m[i] = 1'b0;
    end else begin
      e.ev.h_active = (hc[i] < p.ha);
      e.ev.v_active = (vc[i] < p.va);
      e.ev.hsync    = (hc[i] >= hsb && hc[i] < hsb + p.hs) ? p.hp : ~p.hp;
      e.ev.vsync    = (vc[i] >= vsb && vc[i] < vsb + p.vs) ? p.vp : ~p.vp;
      e.ev.eol      = (hc[i] == p.ha - 1);
      e.ev.eof      = (hc[i] == ht - 1) && (vc[i] == vt - 1);
      e.ev.x        = 10'(hc[i]);
      e.ev.y        = 10'(vc[i]);
`ifdef VGA_TIMING_IRQ_EN
      if (hc[i] == 0 && vc[i] == p.va) irq_m[i] = 1'b1;
      else if (ack)                    irq_m[i] = 1'b0;
      e.ev.irq = irq_m[i];
`else
      e.ev.irq = 1'b0;
`endif
      hc[i]++;
      if (hc[i] == ht) begin
        hc[i] = 0;
        vc[i]++;
        if (vc[i] == vt) vc[i] = 0;
      end
    end
  endtask

  task automatic check(input int i, input prm_t p, input ev_t o, input exp_t e);
    string nm;
    logic  hs_on;
    int    ht, vt;
    nm = (i == 0) ? "small" : "default";
    ht = p.ha + p.hf + p.hs + p.hb;
    vt = p.va + p.vf + p.vs + p.vb;
    n_cmp++;
    if (o !== e.ev) begin
      n_bad++;
      if (n_print < 40) begin
        n_print++;
        $display("FAIL %s outputs: got x=%0d y=%0d hs,vs,ha,va,eol,eof,irq=%b, expected x=%0d y=%0d flags=%b (t=%0t)",
                 nm, o.x, o.y, {o.hsync, o.vsync, o.h_active, o.v_active, o.eol, o.eof, o.irq},
                 e.ev.x, e.ev.y, {e.ev.hsync, e.ev.vsync, e.ev.h_active, e.ev.v_active,
                 e.ev.eol, e.ev.eof, e.ev.irq}, $time);
      end
    end
    if (e.in_rst) begin
      since_rise[i] = 0; ha_run[i] = 0; hs_run[i] = 0; eol_gap[i] = 0;
      fgap[i] = 0; eol_cnt[i] = 0; eol_va[i] = 0;
      rise_ok[i] = 0; eol_seen[i] = 0; prev_ha[i] = 0; prev_hs[i] = 0;
    end else begin
      hs_on = (o.hsync == p.hp);
      since_rise[i]++;
      if (o.h_active && !prev_ha[i]) begin
        since_rise[i] = 0;
        rise_ok[i] = 1;
      end
      if (o.h_active) ha_run[i]++;
      else if (prev_ha[i]) begin
        cmp_int({nm, " h_active run length"}, ha_run[i], p.ha);
        ha_run[i] = 0;
      end
      if (hs_on) begin
        hs_run[i]++;
        if (!prev_hs[i] && rise_ok[i])
          cmp_int({nm, " hsync start after h_active rise"}, since_rise[i], p.ha + p.hf);
      end else if (prev_hs[i]) begin
        cmp_int({nm, " hsync width"}, hs_run[i], p.hs);
        hs_run[i] = 0;
      end
      eol_gap[i]++;
      if (o.eol) begin
        if (eol_seen[i]) cmp_int({nm, " line period"}, eol_gap[i], ht);
        cmp_int({nm, " eol x"}, int'(o.x), p.ha - 1);
        eol_gap[i] = 0;
        eol_seen[i] = 1;
      end
      fgap[i]++;
      eol_cnt[i] += int'(o.eol);
      eol_va[i]  += int'(o.eol & o.v_active);
      if (o.eof) begin
        cmp_int({nm, " frame period"}, fgap[i], ht * vt);
        cmp_int({nm, " eol per frame"}, eol_cnt[i], vt);
        cmp_int({nm, " eol with v_active per frame"}, eol_va[i], p.va);
        fgap[i] = 0; eol_cnt[i] = 0; eol_va[i] = 0;
      end
      prev_ha[i] = o.h_active;
      prev_hs[i] = hs_on;
    end
  endtask

  function automatic ev_t obs_s();
    ev_t o;
    o.hsync = vif_s.hsync; o.vsync = vif_s.vsync;
    o.h_active = vif_s.h_active; o.v_active = vif_s.v_active;
    o.eol = vif_s.eol; o.eof = vif_s.eof; o.x = vif_s.x; o.y = vif_s.y;
`ifdef VGA_TIMING_IRQ_EN
    o.irq = vif_s.vblank_irq;
`else
    o.irq = 1'b0;
`endif
    return o;
  endfunction

  function automatic ev_t obs_d();
    ev_t o;
    o.hsync = vif_d.hsync; o.vsync = vif_d.vsync;
    o.h_active = vif_d.h_active; o.v_active = vif_d.v_active;
    o.eol = vif_d.eol; o.eof = vif_d.eof; o.x = vif_d.x; o.y = vif_d.y;
`ifdef VGA_TIMING_IRQ_EN
    o.irq = vif_d.vblank_irq;
`else
    o.irq = 1'b0;
`endif
    return o;
  endfunction

  // Model: predicts what each DUT shows after every edge.
  initial begin
    exp_t e0, e1;
    forever begin
      @(posedge clk);
      model_step(0, PS, rst_n, ack_s, e0);
      q_s.push_back(e0);
      model_step(1, PD, rst_n, ack_d, e1);
      q_d.push_back(e1);
    end
  end

  // Monitor: compares on the falling edge, away from the sampling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (q_s.size() > 0) check(0, PS, obs_s(), q_s.pop_front());
      if (q_d.size() > 0) check(1, PD, obs_d(), q_d.pop_front());
    end
  end

  bit same_cycle_ack = 1'b1;

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      ack_s = ($urandom_range(0, 7) == 0);
      ack_d = ($urandom_range(0, 15) == 0);
      // Cycle before the flag sets: alternate acking on the set edge and the edge after it.
      if (vif_s.x == 10'(S_HT - 1) && vif_s.y == 10'(S_VA - 1)) begin
        ack_s = same_cycle_ack;
        same_cycle_ack = ~same_cycle_ack;
      end
    end
  endtask

  initial begin
    bit found;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    run(2200);

    found = 1'b0;
    for (int k = 0; k < 3000 && !found; k++) begin
      @(negedge clk);
      ack_s = 1'b0;
      ack_d = 1'b0;
      if (vif_d.x == 10'd700 && vif_d.y == 10'd2) found = 1'b1;
    end
    cmp_int("reach default x=700 y=2", int'(found), 1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int r = 0; r < 8; r++) begin
      run($urandom_range(30, 400));
      if ($urandom_range(0, 1) == 1) begin
        rst_n = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        rst_n = 1'b1;
      end
    end
    run(1500);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
- Free-running raster timing generator. Produces the sync, active-region and end-of-line strobes consumed by the graphics-mode fetch/pixel stages (gm_* blocks) and by the VGA pad outputs.
- Sits directly upstream of the graphics modes. Their pixel/row counters and line-fetch sequencers run from this block's h_active, v_active and eol.
- One pixel per clk_i cycle; no clock enable.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch in clocks
- H_SYNC, 96, hsync pulse width in clocks
- H_BACK, 48, horizontal back porch in clocks
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch in lines
- V_SYNC, 2, vsync pulse width in lines
- V_BACK, 33, vertical back porch in lines
- HS_POL, 0, hsync asserted level (0 = active-low)
- VS_POL, 0, vsync asserted level (0 = active-low)
- CW, 10, width of the h/v counters; H and V totals must each be ≤ 2^CW

Ports:
- clk_i  in  1  pixel clock
- rst_i  in  1  reset, synchronous, active-low
- hsync  out  1  horizontal sync, polarity per HS_POL
- vsync  out  1  vertical sync, polarity per VS_POL
- h_active  out  1  high during the visible part of a line
- v_active  out  1  high during visible lines
- eol  out  1  one-cycle pulse on the last visible pixel of every line
- eof  out  1  one-cycle pulse on the last clock of the frame
- x  out  CW  current horizontal count, 0..H_TOTAL-1
- y  out  CW  current line count, 0..V_TOTAL-1
- vblank_irq  out  1  sticky vertical-blank flag (VGA_TIMING_IRQ_EN only)
- irq_ack  in  1  clears vblank_irq (VGA_TIMING_IRQ_EN only)

Behaviour:
- Totals: H_TOTAL = sum of the four H parameters (800); V_TOTAL = sum of the four V parameters (525).
- hcount increments every clock and wraps H_TOTAL-1 → 0.
- vcount increments only on the clock where hcount wraps, and wraps V_TOTAL-1 → 0.
- Each axis has region states ACTIVE → FRONT → SYNC → BACK → ACTIVE.
  - H boundaries: H_ACTIVE, +H_FRONT, +H_SYNC, and the wrap.
  - V boundaries: the same pattern on vcount.
- All outputs are registered and reflect the counter value from the previous cycle (one-cycle latency).
- hsync = HS_POL while the H region is SYNC, otherwise ~HS_POL. vsync behaves the same with VS_POL.
- h_active while the H region is ACTIVE; v_active while the V region is ACTIVE.
- eol when hcount == H_ACTIVE-1, on every line including vblank lines. Consumers start line prefetch on it and advance their row count with v_active && eol.
- eof when hcount == H_TOTAL-1 && vcount == V_TOTAL-1.
- x = hcount, y = vcount (registered).
- Reset values (rst_i low at a clock edge):
  - hcount = vcount = 0
  - hsync = ~HS_POL, vsync = ~VS_POL
  - h_active = v_active = eol = eof = 0
  - x = y = 0
  - vblank_irq = 0
- First clock edge with rst_i high: outputs load the decode of (0,0), so h_active = v_active = 1 and hsync/vsync are inactive.
- Reset mid-frame: the next edge with rst_i low forces the reset values regardless of region. The raster restarts at (0,0) with no partial sync pulse emitted after release.
- Per line: h_active high for exactly H_ACTIVE consecutive clocks; hsync asserted for exactly H_SYNC clocks, starting H_ACTIVE+H_FRONT clocks after h_active rises.
- Per frame: exactly V_TOTAL eol pulses, of which V_ACTIVE coincide with v_active.

Optional Feature:
- Macro: VGA_TIMING_IRQ_EN.
- Defined: the vblank_irq and irq_ack ports exist.
  - vblank_irq sets on the clock the V region enters FRONT, i.e. the first line after the last visible line, at hcount 0.
  - It stays set until irq_ack is sampled high.
  - Set and ack in the same cycle: set wins, flag remains 1.
- Undefined: neither port exists and no flag logic is built; all other behaviour is identical.

Decomposition:
- Package vga_timing_pkg holds:
  - typedef enum region_t {R_ACTIVE, R_FRONT, R_SYNC, R_BACK}
  - the default 640x480@60 constants
  - a function computing a total from the four segment lengths
- Sub-module vga_axis_counter, instantiated twice (horizontal and vertical).
  - Inputs: clk_i, rst_i, inc, the four segment lengths.
  - Outputs: count, region_t region, wrap (asserted when inc && count == total-1).
  - The horizontal instance has inc tied to 1; the vertical instance has inc = h.wrap.

Test Plan:
- Reset release with default params → h_active high on the first edge after release; falls after 640 clocks; hsync low for clocks 656..751 of the line; line period 800 clocks.
- Run one full frame → exactly 525 eol pulses, 480 while v_active; vsync low for lines 490..491; eof single pulse at x=799, y=524; frame period 420000 clocks.
- Check eol timing → eol coincides with x==639 on every line, and h_active falls the following cycle.
- Assert rst_i low at x=700, y=300 for 3 clocks → outputs at reset values while low; after release x/y restart 0,1,2…; no spurious hsync/vsync pulse.
- With VGA_TIMING_IRQ_EN: vblank_irq rises at y=480, x=0. Hold irq_ack high on that exact cycle → flag stays 1. Ack one cycle later → flag 0 until the next frame's y=480.
- Reduced params (H 8/2/2/2, V 4/1/1/1, HS_POL=VS_POL=1) → line 14 clocks, frame 98 clocks; sync pulses active-high; 7 eol pulses per frame.
